// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Holds the scoreboard entry layout, FSM encodings and the source-match helper.
package hazard_scoreboard_pkg;

  localparam int DEPTH_DEF = 2;
  localparam logic [2:0] R7 = 3'd7;

  typedef struct packed {
    logic       v;
    logic [2:0] dest;
  } sb_entry_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // True when a live in-flight writer targets a register the decoding instruction reads.
  function automatic logic src_match(input sb_entry_t e,
                                     input logic use_rs, input logic [2:0] rs,
                                     input logic use_rt, input logic [2:0] rt);
    return e.v & ((use_rs & (rs == e.dest)) | (use_rt & (rt == e.dest)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry_shift.sv
// DEPTH-entry shift register of in-flight destination registers.
// Entry 0 is the instruction entering EX; entry DEPTH-1 is in MEM.
module sb_entry_shift
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  sb_entry_t             din,
  output sb_entry_t [DEPTH-1:0] entries
);

  // NOTE: this small array is reset because its valid bits gate hazards; wide
  // data-only memories would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else if (en) begin
      entries[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard unit: stalls on in-flight writers, squashes on flush,
// drains after HALT and counts hazard-stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_D,
  input  logic [2:0]       rs_D,
  input  logic [2:0]       rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             regWrite_D,
  input  logic             writeR7_D,
  input  logic [2:0]       writeRegSel_D,
  input  logic             HALT_D,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             stall_FD,
  output logic             bubble_DX,
  output logic             en_DX,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  sb_entry_t [DEPTH-1:0] entries;
  sb_entry_t             new_entry;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  match;
  logic                  any_valid;
  logic                  run;
  logic                  hazard;
  logic                  issue;
  logic                  cnt_inc;
  logic [2:0]            dest_D;
  logic                  wr_D;

  assign dest_D = writeR7_D ? R7 : writeRegSel_D;
  assign wr_D   = regWrite_D | writeR7_D;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    match     = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match     = match | src_match(entries[i], use_rs_D, rs_D, use_rt_D, rt_D);
      any_valid = any_valid | entries[i].v;
    end
  end

  assign run     = (state == ST_RUN);
  assign hazard  = valid_D & match & run;
  assign issue   = valid_D & ~hazard & ~flush & ~mem_stall & run;
  assign cnt_inc = hazard & ~flush & ~mem_stall;

  assign stall_FD  = mem_stall | (hazard & ~flush) | ~run;
  assign bubble_DX = ~issue;
  assign en_DX     = ~mem_stall;
  assign halted    = (state == ST_HALTED);

  assign new_entry.v    = issue & wr_D;
  assign new_entry.dest = dest_D;

  sb_entry_shift #(.DEPTH(DEPTH)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .en      (~mem_stall),
    .din     (new_entry),
    .entries (entries)
  );

  // DRAIN completes once no writer remains ahead of the HALT and the pipe moves.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (issue & HALT_D) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (~any_valid & ~mem_stall) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_inc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor
// pops and compares them against the DUT.
module tb_hazard_scoreboard;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 8;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  typedef struct packed {
    bit       rst;
    bit       valid;
    bit [2:0] rs;
    bit [2:0] rt;
    bit       use_rs;
    bit       use_rt;
    bit       reg_write;
    bit       write_r7;
    bit [2:0] wsel;
    bit       halt;
    bit       flush;
    bit       mem_stall;
  } stim_t;

  typedef struct packed {
    bit             stall_fd;
    bit             bubble;
    bit             en;
    bit             halted;
    bit [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    bit [2:0] dest;
    int       life;
  } writer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_D = 1'b0, use_rs_D = 1'b0, use_rt_D = 1'b0;
  logic regWrite_D = 1'b0, writeR7_D = 1'b0, HALT_D = 1'b0;
  logic flush = 1'b0, mem_stall = 1'b0;
  logic [2:0] rs_D = '0, rt_D = '0, writeRegSel_D = '0;
  logic stall_FD, bubble_DX, en_DX, halted;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  exp_t    exp_q[$];
  writer_t pend[$];
  int      mstate = M_RUN;
  int      mcnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .rs_D(rs_D), .rt_D(rt_D),
    .use_rs_D(use_rs_D), .use_rt_D(use_rt_D), .regWrite_D(regWrite_D),
    .writeR7_D(writeR7_D), .writeRegSel_D(writeRegSel_D), .HALT_D(HALT_D),
    .flush(flush), .mem_stall(mem_stall), .stall_FD(stall_FD),
    .bubble_DX(bubble_DX), .en_DX(en_DX), .halted(halted), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_FD", {31'b0, stall_FD}, {31'b0, e.stall_fd});
      check("bubble_DX", {31'b0, bubble_DX}, {31'b0, e.bubble});
      check("en_DX", {31'b0, en_DX}, {31'b0, e.en});
      check("halted", {31'b0, halted}, {31'b0, e.halted});
      check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end

  // Apply one cycle of stimulus and predict the outputs from pipeline-level rules.
  task automatic drive(input stim_t s);
    bit   hit, run, hazard, issue, drained;
    exp_t e;
    writer_t nxt[$];
    @(posedge clk);
    #1;
    rst = s.rst; valid_D = s.valid; rs_D = s.rs; rt_D = s.rt;
    use_rs_D = s.use_rs; use_rt_D = s.use_rt; regWrite_D = s.reg_write;
    writeR7_D = s.write_r7; writeRegSel_D = s.wsel; HALT_D = s.halt;
    flush = s.flush; mem_stall = s.mem_stall;
    if (s.rst) begin
      pend.delete();
      mstate = M_RUN;
      mcnt = 0;
    end
    hit = 0;
    foreach (pend[i])
      if ((s.use_rs && s.rs == pend[i].dest) || (s.use_rt && s.rt == pend[i].dest)) hit = 1;
    run    = (mstate == M_RUN);
    hazard = s.valid && hit && run;
    issue  = s.valid && !hazard && !s.flush && !s.mem_stall && run;
    e.stall_fd = s.mem_stall || (hazard && !s.flush) || !run;
    e.bubble   = !issue;
    e.en       = !s.mem_stall;
    e.halted   = (mstate == M_HALT);
    e.cnt      = CNT_W'(mcnt);
    exp_q.push_back(e);
    if (!s.rst) begin
      drained = (pend.size() == 0);
      if (hazard && !s.flush && !s.mem_stall && mcnt < (1 << CNT_W) - 1) mcnt++;
      if (mstate == M_RUN && issue && s.halt) mstate = M_DRAIN;
      else if (mstate == M_DRAIN && drained && !s.mem_stall) mstate = M_HALT;
      if (!s.mem_stall) begin
        foreach (pend[i])
          if (pend[i].life > 1) nxt.push_back('{pend[i].dest, pend[i].life - 1});
        pend = nxt;
        if (issue && (s.reg_write || s.write_r7))
          pend.push_back('{s.write_r7 ? 3'd7 : s.wsel, DEPTH});
      end
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t alu(input bit [2:0] dest, input bit [2:0] rs, input bit urs,
                                input bit [2:0] rt, input bit urt);
    stim_t s;
    s = '0;
    s.valid = 1; s.reg_write = 1; s.wsel = dest;
    s.rs = rs; s.use_rs = urs; s.rt = rt; s.use_rt = urt;
    return s;
  endfunction

  function automatic stim_t do_reset();
    stim_t s;
    s = '0;
    s.rst = 1;
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    int    saved;
    int    halted_run;

    drive(do_reset());
    drive(do_reset());
    @(negedge clk);
    check("reset_halted", {31'b0, halted}, 0);
    check("reset_cnt", 32'(stall_cnt), 0);

    // ADDI r1 then dependent ADD r2,r1,r3 held in decode.
    drive(alu(1, 0, 1, 0, 0));
    drive(alu(2, 1, 1, 3, 1));
    @(negedge clk); check("raw_stall1", {31'b0, stall_FD}, 1);
    drive(alu(2, 1, 1, 3, 1));
    @(negedge clk); check("raw_stall2", {31'b0, bubble_DX}, 1);
    drive(alu(2, 1, 1, 3, 1));
    @(negedge clk);
    check("raw_issue", {31'b0, bubble_DX}, 0);
    check("raw_cnt", 32'(stall_cnt), 2);
    repeat (3) drive(nop());

    // JAL, one independent slot, then a reader of r7 (one stall) or r6 (none).
    s = nop(); s.valid = 1; s.write_r7 = 1; s.wsel = 3'd2;
    drive(s);
    drive(alu(3, 0, 0, 0, 0));
    drive(alu(4, 7, 1, 0, 0));
    @(negedge clk); check("jal_r7_stall", {31'b0, stall_FD}, 1);
    drive(alu(4, 7, 1, 0, 0));
    @(negedge clk); check("jal_r7_issue", {31'b0, bubble_DX}, 0);
    repeat (3) drive(nop());
    drive(s);
    drive(alu(3, 0, 0, 0, 0));
    drive(alu(4, 6, 1, 0, 0));
    @(negedge clk); check("jal_r6_nostall", {31'b0, bubble_DX}, 0);
    repeat (3) drive(nop());

    // Flush coinciding with a hazard: flush wins, nothing inserted.
    saved = mcnt;
    drive(alu(4, 0, 0, 0, 0));
    s = alu(5, 4, 1, 0, 0); s.flush = 1;
    drive(s);
    @(negedge clk);
    check("flush_stall", {31'b0, stall_FD}, 0);
    check("flush_bubble", {31'b0, bubble_DX}, 1);
    check("flush_cnt", 32'(stall_cnt), 32'(saved));
    drive(alu(6, 5, 1, 0, 0));
    @(negedge clk); check("flush_no_entry", {31'b0, bubble_DX}, 0);
    repeat (3) drive(nop());

    // mem_stall freezes the scoreboard with a producer of r1 in EX.
    drive(alu(1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      s = alu(2, 1, 1, 0, 0); s.mem_stall = 1;
      drive(s);
      @(negedge clk);
      check("ms_en", {31'b0, en_DX}, 0);
      check("ms_stall", {31'b0, stall_FD}, 1);
    end
    drive(alu(2, 1, 1, 0, 0));
    @(negedge clk); check("ms_after1", {31'b0, stall_FD}, 1);
    drive(alu(2, 1, 1, 0, 0));
    @(negedge clk); check("ms_after2", {31'b0, stall_FD}, 1);
    drive(alu(2, 1, 1, 0, 0));
    @(negedge clk); check("ms_issue", {31'b0, bubble_DX}, 0);
    repeat (3) drive(nop());

    // HALT drains: halted two cycles after issue when nothing writes ahead.
    drive(do_reset());
    s = nop(); s.valid = 1; s.halt = 1;
    drive(s);
    drive(nop());
    @(negedge clk);
    check("drain_stall", {31'b0, stall_FD}, 1);
    check("drain_halted", {31'b0, halted}, 0);
    drive(nop());
    @(negedge clk); check("halted_rise", {31'b0, halted}, 1);
    drive(alu(3, 0, 0, 0, 0));
    @(negedge clk); check("halted_stall", {31'b0, stall_FD}, 1);

    // Reset mid-DRAIN after accumulating some stall cycles.
    drive(do_reset());
    drive(alu(1, 0, 0, 0, 0));
    repeat (3) drive(alu(2, 1, 1, 0, 0));
    s = nop(); s.valid = 1; s.halt = 1;
    drive(s);
    drive(do_reset());
    @(negedge clk);
    check("rst_drain_halted", {31'b0, halted}, 0);
    check("rst_drain_cnt", 32'(stall_cnt), 0);
    check("rst_drain_stall", {31'b0, stall_FD}, 0);
    drive(alu(3, 0, 0, 0, 0));
    @(negedge clk); check("rst_drain_run", {31'b0, bubble_DX}, 0);

    // Self-dependent chain keeps re-stalling until the counter saturates.
    drive(do_reset());
    repeat (450) drive(alu(1, 1, 1, 0, 0));
    @(negedge clk); check("cnt_saturate", 32'(stall_cnt), 32'((1 << CNT_W) - 1));

    // Randomized traffic with small register range to provoke hazards.
    drive(do_reset());
    halted_run = 0;
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.valid     = ($urandom_range(0, 3) != 0);
      s.rs        = 3'($urandom_range(0, 3));
      s.rt        = 3'($urandom_range(0, 3));
      s.use_rs    = 1'($urandom);
      s.use_rt    = 1'($urandom);
      s.reg_write = ($urandom_range(0, 4) < 3);
      s.write_r7  = ($urandom_range(0, 9) == 0);
      s.wsel      = 3'($urandom_range(0, 7));
      s.halt      = ($urandom_range(0, 39) == 0);
      s.flush     = ($urandom_range(0, 9) == 0);
      s.mem_stall = ($urandom_range(0, 4) == 0);
      halted_run  = (mstate == M_HALT) ? halted_run + 1 : 0;
      s.rst       = ($urandom_range(0, 99) == 0) || (halted_run > 6);
      drive(s);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
